// File: rtl/valid_delay_line.sv
// DEPTH-stage register pipeline carrying a valid bit alongside WIDTH-bit data.
// Supports global stall, bubble-clearing flush, and a live occupancy count.
module valid_delay_line #(
  parameter int                 WIDTH       = 8,
  parameter int                 DEPTH       = 4,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_reg [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [WIDTH-1:0] data_next [DEPTH];
  logic [DEPTH-1:0] valid_next;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign data_next[gi]  = in;
        assign valid_next[gi] = in_valid;
      end else begin : g_body
        assign data_next[gi]  = data_reg[gi-1];
        assign valid_next[gi] = valid_reg[gi-1];
      end

      // Flush clears only the valid bits; data is left in place as don't-care.
      always_ff @(posedge clk) begin
        if (reset) begin
          data_reg[gi]  <= RESET_VALUE;
          valid_reg[gi] <= 1'b0;
        end else if (flush) begin
          valid_reg[gi] <= 1'b0;
        end else if (enable) begin
          data_reg[gi]  <= data_next[gi];
          valid_reg[gi] <= valid_next[gi];
        end
      end
    end
  endgenerate

  // Occupancy depends only on registered valid bits, so no input reaches it combinationally.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(valid_reg[i]);
    end
  end

  assign out       = data_reg[DEPTH-1];
  assign out_valid = valid_reg[DEPTH-1];

endmodule

// File: tb/tb_valid_delay_line.sv
// Randomised and directed bench for valid_delay_line at DEPTH=3 and DEPTH=1,
// checked against a history-based model of accepted samples.
module tb_valid_delay_line;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b0, enable = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [7:0] in = 8'h00;
  logic [7:0] out3, out1;
  logic       ov3, ov1;
  logic [1:0] occ3;
  logic [0:0] occ1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  valid_delay_line #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5)) u_dut3 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .in(in), .in_valid(in_valid),
    .out(out3), .out_valid(ov3), .occupancy(occ3)
  );

  valid_delay_line #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'hA5)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .in(in), .in_valid(in_valid),
    .out(out1), .out_valid(ov1), .occupancy(occ1)
  );

  // Model: every sample accepted on an enabled edge since the last reset,
  // plus the index before which a flush has invalidated everything.
  logic [7:0] hist_d[$];
  bit         hist_v[$];
  int         n_acc = 0;
  int         flush_mark = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_expect(input int depth, output logic [7:0] ed, output bit ev, output int eo);
    int lo;
    ed = RV;
    ev = 1'b0;
    eo = 0;
    if (n_acc >= depth) begin
      ed = hist_d[n_acc - depth];
      ev = hist_v[n_acc - depth] && ((n_acc - depth) >= flush_mark);
    end
    lo = (n_acc > depth) ? n_acc - depth : 0;
    for (int i = lo; i < n_acc; i++) begin
      if (hist_v[i] && i >= flush_mark) eo++;
    end
  endtask

  task automatic check_all();
    logic [7:0] ed;
    bit         ev;
    int         eo;
    model_expect(3, ed, ev, eo);
    check("d3_out_valid", ov3, ev);
    check("d3_occupancy", occ3, eo);
    if (ev || n_acc < 3) check("d3_out", out3, ed);
    model_expect(1, ed, ev, eo);
    check("d1_out_valid", ov1, ev);
    check("d1_occupancy", occ1, eo);
    if (ev || n_acc < 1) check("d1_out", out1, ed);
    $display("t=%0t rst=%0b fl=%0b en=%0b iv=%0b in=%02h | d3 out=%02h v=%0b occ=%0d | d1 out=%02h v=%0b occ=%0d",
             $time, reset, flush, enable, in_valid, in, out3, ov3, occ3, out1, ov1, occ1);
  endtask

  task automatic step(input bit r, input bit f, input bit e, input bit iv, input logic [7:0] d);
    reset = r; flush = f; enable = e; in_valid = iv; in = d;
    @(posedge clk);
    if (r) begin
      hist_d.delete();
      hist_v.delete();
      n_acc = 0;
      flush_mark = 0;
    end else if (f) begin
      flush_mark = n_acc;
    end else if (e) begin
      hist_d.push_back(d);
      hist_v.push_back(iv);
      n_acc++;
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset held for two edges
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);

    // Back-to-back stream 01..04, then drain
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 1, 8'(i));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h00);

    // Single word across a five-cycle stall
    step(0, 0, 1, 1, 8'h11);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 8'hEE);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h00);

    // Alternating valid pattern
    step(0, 0, 1, 1, 8'h21);
    step(0, 0, 1, 0, 8'h22);
    step(0, 0, 1, 1, 8'h23);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h00);

    // Flush with a full pipeline while presenting a valid word
    step(0, 0, 1, 1, 8'h31);
    step(0, 0, 1, 1, 8'h32);
    step(0, 0, 1, 1, 8'h33);
    step(0, 1, 1, 1, 8'h99);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'h00);

    // Reset and flush together mid-stream
    step(0, 0, 1, 1, 8'h41);
    step(0, 0, 1, 1, 8'h42);
    step(1, 1, 1, 1, 8'h43);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 8'h50 + 8'(i));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 6),
           ($urandom_range(0, 99) < 75), 1'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
